regf_apb_bridge: RTL

- APB4 slave front-end that converts APB transfers into the single-cycle mem_* strobe interface consumed by generated register files (mem_ena/mem_addr/mem_wena/mem_wdata in, mem_rdata/mem_err out).
- Sits directly upstream of a *_regf instance. Registers all mem_* outputs, inserts wait states via pready, and maps mem_err to pslverr.
- Handles byte-strobe partial writes by read-modify-write.

---
 rtl/regf_apb_bridge_if.sv | 34 +++
 rtl/regf_apb_bridge.sv | 134 +++++++++++++
 2 files changed

// File: rtl/regf_apb_bridge_if.sv
// APB4 slave bus plus the regf mem_* strobe bus, seen from the bridge (slave) or its environment (master).
interface regf_apb_bridge_if #(
  parameter int MEM_ADDR_WIDTH = 13
);
  logic                      apb_psel_i;
  logic                      apb_penable_i;
  logic                      apb_pwrite_i;
  logic [MEM_ADDR_WIDTH+1:0] apb_paddr_i;
  logic [31:0]               apb_pwdata_i;
  logic [3:0]                apb_pstrb_i;
  logic [31:0]               apb_prdata_o;
  logic                      apb_pready_o;
  logic                      apb_pslverr_o;
  logic                      mem_ena_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic                      mem_wena_o;
  logic [31:0]               mem_wdata_o;
  logic [31:0]               mem_rdata_i;
  logic                      mem_err_i;

  modport slave (
    input  apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_i, apb_pwdata_i, apb_pstrb_i,
    output apb_prdata_o, apb_pready_o, apb_pslverr_o,
    output mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
    input  mem_rdata_i, mem_err_i
  );

  modport master (
    output apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_i, apb_pwdata_i, apb_pstrb_i,
    input  apb_prdata_o, apb_pready_o, apb_pslverr_o,
    input  mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
    output mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/regf_apb_bridge.sv
// APB4 slave -> single-cycle regf mem_* strobe bridge with registered outputs.
// Define REGF_APB_PSTRB_RMW_EN to honour partial byte strobes via read-modify-write.
module regf_apb_bridge #(
  parameter int MEM_ADDR_WIDTH = 13
) (
  input  logic              main_clk_i,
  input  logic              main_rst_i,
  regf_apb_bridge_if.slave  bus
);

`ifdef REGF_APB_PSTRB_RMW_EN
  typedef enum logic [2:0] {IDLE, ACC, RMW_RD, RMW_WR, RESP} state_e;
`else
  typedef enum logic [2:0] {IDLE, ACC, RESP} state_e;
`endif

  state_e                    state_q;
  logic                      write_q;
  logic                      mem_ena_q;
  logic                      mem_wena_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]               mem_wdata_q;
  logic [31:0]               prdata_q;
  logic                      pslverr_q;
  logic                      pready_q;

`ifdef REGF_APB_PSTRB_RMW_EN
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [31:0] merged_d;

  // Strobed bytes come from the APB write, the rest from the word just read.
  always_comb begin
    merged_d = wdata_q;
    for (int b = 0; b < 4; b++)
      if (!strb_q[b]) merged_d[8*b +: 8] = bus.mem_rdata_i[8*b +: 8];
  end
`endif

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      mem_ena_q   <= 1'b0;
      mem_wena_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      pready_q    <= 1'b0;
`ifdef REGF_APB_PSTRB_RMW_EN
      wdata_q     <= '0;
      strb_q      <= '0;
`endif
    end else begin
      mem_ena_q <= 1'b0;
      pready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Accept only in the setup phase so the trailing access phase of the last transfer is ignored.
          if (bus.apb_psel_i && !bus.apb_penable_i) begin
            write_q <= bus.apb_pwrite_i;
`ifdef REGF_APB_PSTRB_RMW_EN
            wdata_q <= bus.apb_pwdata_i;
            strb_q  <= bus.apb_pstrb_i;
`endif
            if (bus.apb_paddr_i[1:0] != 2'b00) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else if (bus.apb_pwrite_i && bus.apb_pstrb_i == 4'h0) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b0;
`ifdef REGF_APB_PSTRB_RMW_EN
            end else if (bus.apb_pwrite_i && bus.apb_pstrb_i != 4'hF) begin
              state_q    <= RMW_RD;
              mem_ena_q  <= 1'b1;
              mem_wena_q <= 1'b0;
              mem_addr_q <= bus.apb_paddr_i[MEM_ADDR_WIDTH+1:2];
`endif
            end else begin
              state_q     <= ACC;
              mem_ena_q   <= 1'b1;
              mem_wena_q  <= bus.apb_pwrite_i;
              mem_addr_q  <= bus.apb_paddr_i[MEM_ADDR_WIDTH+1:2];
              mem_wdata_q <= bus.apb_pwdata_i;
            end
          end
        end
        ACC: begin
          prdata_q  <= write_q ? 32'h0 : bus.mem_rdata_i;
          pslverr_q <= bus.mem_err_i;
          pready_q  <= 1'b1;
          state_q   <= RESP;
        end
`ifdef REGF_APB_PSTRB_RMW_EN
        RMW_RD: begin
          if (bus.mem_err_i) begin
            pslverr_q <= 1'b1;
            pready_q  <= 1'b1;
            state_q   <= RESP;
          end else begin
            mem_ena_q   <= 1'b1;
            mem_wena_q  <= 1'b1;
            mem_wdata_q <= merged_d;
            state_q     <= RMW_WR;
          end
        end
        RMW_WR: begin
          pslverr_q <= bus.mem_err_i;
          pready_q  <= 1'b1;
          state_q   <= RESP;
        end
`endif
        RESP: begin
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.apb_prdata_o  = prdata_q;
  assign bus.apb_pready_o  = pready_q;
  assign bus.apb_pslverr_o = pslverr_q;
  assign bus.mem_ena_o     = mem_ena_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wena_o    = mem_wena_q;
  assign bus.mem_wdata_o   = mem_wdata_q;

endmodule
